// File: rtl/punc_datapath.sv
// rtl/punc_datapath.sv - PUNC datapath: PC, IR, store reg, 8x16 register file, ALU, NZP flags, memory port muxing
//
// Purpose: datapath for the PUNC 16-bit processor; every strobe and select comes
// from an external controller, and memory is read combinationally.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   PC_data_sel, PC_add_sel      PC load source / PC adder base select
//   PC_ld, PC_clr, PC_inc        PC load / clear / increment strobes
//   IR_ld, store_ld              IR / store register load strobes (from mem_rdata)
//   addr_MEM_sel                 mem_addr source: PC, PC adder, store reg, ALU
//   w_en_MEM, rst_MEM            memory write / clear requests
//   w_RF_sel, w_addr_RF, w_en_RF RF write data select, address, enable
//   r_addr_0/1/2_RF, rst_RF      RF read addresses (port 2 debug), RF clear
//   sext_data                    PC offset width: 0 = IR[10:0], 1 = IR[8:0]
//   A_sel, B_sel, ALU_sel        ALU operand and operation selects
//   NZP_sel, N_ld, Z_ld, P_ld    flag source and per-flag load strobes
//   IR, RF_data, n, z, p         instruction register, debug read data, flags
//   mem_addr, mem_wdata,
//   mem_we, mem_rst, mem_rdata   memory interface
module punc_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_data_sel,
  input  logic        PC_add_sel,
  input  logic        PC_ld,
  input  logic        PC_clr,
  input  logic        PC_inc,
  input  logic        IR_ld,
  input  logic [1:0]  addr_MEM_sel,
  input  logic        w_en_MEM,
  input  logic        rst_MEM,
  input  logic [1:0]  w_RF_sel,
  input  logic [2:0]  r_addr_0_RF,
  input  logic [2:0]  r_addr_1_RF,
  input  logic [2:0]  r_addr_2_RF,
  input  logic [2:0]  w_addr_RF,
  input  logic        w_en_RF,
  input  logic        rst_RF,
  input  logic        sext_data,
  input  logic        A_sel,
  input  logic        B_sel,
  input  logic [1:0]  ALU_sel,
  input  logic        NZP_sel,
  input  logic        N_ld,
  input  logic        Z_ld,
  input  logic        P_ld,
  input  logic        store_ld,
  output logic [15:0] IR,
  output logic [15:0] RF_data,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_rst,
  input  logic [15:0] mem_rdata
);

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_store;
  logic [15:0] r_rf [8];
  logic        r_n, r_z, r_p;

  logic [15:0] w_rf0, w_rf1;
  logic [15:0] w_imm, w_offs, w_pc_base, w_pc_add;
  logic [15:0] w_alu_a, w_alu_b, w_alu;
  logic [15:0] w_rf_wdata, w_pc_next, w_flag_src;

  // Reads are plain array lookups, so a same-cycle write is not bypassed.
  assign w_rf0   = r_rf[r_addr_0_RF];
  assign w_rf1   = r_rf[r_addr_1_RF];
  assign RF_data = r_rf[r_addr_2_RF];

  // IR[13] separates the imm6 (LDR/STR) encodings from the imm5 (ADD/AND) ones.
  assign w_imm = r_ir[13] ? {{10{r_ir[5]}}, r_ir[5:0]} : {{11{r_ir[4]}}, r_ir[4:0]};

  assign w_offs    = sext_data ? {{7{r_ir[8]}}, r_ir[8:0]} : {{5{r_ir[10]}}, r_ir[10:0]};
  assign w_pc_base = PC_add_sel ? w_rf0 : r_pc;
  assign w_pc_add  = w_pc_base + w_offs;

  assign w_alu_a = A_sel ? w_rf0 : r_pc;
  assign w_alu_b = B_sel ? w_imm : w_rf1;

  always_comb begin
    w_alu = ~w_alu_a;
    case (ALU_sel)
      ALU_ADD:  w_alu = w_alu_a + w_alu_b;
      ALU_AND:  w_alu = w_alu_a & w_alu_b;
      ALU_PASS: w_alu = w_alu_a;
      default:  w_alu = ~w_alu_a;
    endcase
  end

  always_comb begin
    mem_addr = r_pc;
    case (addr_MEM_sel)
      2'b00:   mem_addr = r_pc;
      2'b01:   mem_addr = w_pc_add;
      2'b10:   mem_addr = r_store;
      default: mem_addr = w_alu;
    endcase
  end

  always_comb begin
    w_rf_wdata = r_pc;
    case (w_RF_sel)
      2'b00:   w_rf_wdata = r_pc;
      2'b01:   w_rf_wdata = mem_rdata;
      2'b10:   w_rf_wdata = w_alu;
      default: w_rf_wdata = w_pc_add;
    endcase
  end

  // Clear beats load beats increment.
  always_comb begin
    w_pc_next = r_pc;
    if (PC_clr)
      w_pc_next = 16'h0000;
    else if (PC_ld)
      w_pc_next = PC_data_sel ? w_rf0 : w_pc_add;
    else if (PC_inc)
      w_pc_next = r_pc + 16'h0001;
  end

  assign w_flag_src = NZP_sel ? mem_rdata : w_alu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= 16'h0000;
      r_ir    <= 16'h0000;
      r_store <= 16'h0000;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
      r_p     <= 1'b0;
      for (int i = 0; i < 8; i++)
        r_rf[i] <= 16'h0000;
    end else begin
      r_pc <= w_pc_next;
      if (IR_ld)
        r_ir <= mem_rdata;
      if (store_ld)
        r_store <= mem_rdata;
      if (rst_RF) begin
        for (int i = 0; i < 8; i++)
          r_rf[i] <= 16'h0000;
      end else if (w_en_RF) begin
        r_rf[w_addr_RF] <= w_rf_wdata;
      end
      if (N_ld)
        r_n <= w_flag_src[15];
      if (Z_ld)
        r_z <= (w_flag_src == 16'h0000);
      if (P_ld)
        r_p <= !w_flag_src[15] && (w_flag_src != 16'h0000);
    end
  end

  assign IR        = r_ir;
  assign n         = r_n;
  assign z         = r_z;
  assign p         = r_p;
  assign mem_wdata = w_rf1;
  assign mem_we    = w_en_MEM & !rst;
  assign mem_rst   = rst_MEM | rst;

endmodule
